// File: rtl/rob_pkg.sv
// rob_pkg: reorder buffer sizing and entry layout shared with rename/issue/commit.
// ROB_DEBUG_TRACE_EN adds a per-entry pc field for retire tracing.
package rob_pkg;

    localparam int ROB_DEPTH     = 16;
    localparam int MACHINE_WIDTH = 2;
    localparam int ALU_NUM       = 2;
    localparam int MEM_NUM       = 1;
    localparam int ROB_AW        = $clog2(ROB_DEPTH);
    localparam int PREG_AW       = 6;

    typedef logic [ROB_AW-1:0]  rob_addr_t;
    typedef logic [ROB_AW:0]    rob_ptr_t;
    typedef logic [PREG_AW-1:0] preg_addr_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  creg;
        preg_addr_t  preg;
        logic [31:0] data;
        logic        is_branch;
        logic        redirect;
        logic [31:0] target;
`ifdef ROB_DEBUG_TRACE_EN
        logic [31:0] pc;
`endif
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// rob_retire_sel: two-wide retire decision from the head and head+1 entries.
// A redirect entry only leaves together with its delay slot.
module rob_retire_sel (
    input  logic       head_valid,
    input  logic       head_done,
    input  logic       head_redirect,
    input  logic       next_valid,
    input  logic       next_done,
    input  logic       next_redirect,
    output logic [1:0] retire_valid,
    output logic [1:0] head_inc,
    output logic       redirect
);

    logic head_rdy;
    logic next_rdy;

    assign head_rdy = head_valid & head_done;
    assign next_rdy = next_valid & next_done;

    // Pick how many head entries leave this cycle and whether they redirect.
    always_comb begin
        retire_valid = 2'b00;
        head_inc     = 2'd0;
        redirect     = 1'b0;
        if (head_rdy && head_redirect) begin
            if (next_rdy) begin
                retire_valid = 2'b11;
                head_inc     = 2'd2;
                redirect     = 1'b1;
            end
        end else if (head_rdy) begin
            retire_valid[0] = 1'b1;
            head_inc        = 2'd1;
            if (next_rdy && !next_redirect) begin
                retire_valid[1] = 1'b1;
                head_inc        = 2'd2;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with branch redirect and flush.
// ROB_DEBUG_TRACE_EN adds alloc_pc and the debug_wb_* retire trace ports.
module reorder_buffer #(
    parameter int ROB_DEPTH     = rob_pkg::ROB_DEPTH,
    parameter int MACHINE_WIDTH = rob_pkg::MACHINE_WIDTH,
    parameter int ALU_NUM       = rob_pkg::ALU_NUM,
    parameter int MEM_NUM       = rob_pkg::MEM_NUM,
    localparam int AW           = $clog2(ROB_DEPTH),
    localparam int PW           = rob_pkg::PREG_AW
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MACHINE_WIDTH-1:0]           alloc_valid,
    input  logic [MACHINE_WIDTH-1:0][4:0]      alloc_dst_creg,
    input  logic [MACHINE_WIDTH-1:0][PW-1:0]   alloc_dst_preg,
    input  logic [MACHINE_WIDTH-1:0]           alloc_is_branch,
`ifdef ROB_DEBUG_TRACE_EN
    input  logic [MACHINE_WIDTH-1:0][31:0]     alloc_pc,
`endif
    output logic                               alloc_ready,
    output logic [MACHINE_WIDTH-1:0][AW-1:0]   rob_addr_new,
    input  logic [ALU_NUM-1:0]                 alu_valid,
    input  logic [ALU_NUM-1:0][AW-1:0]         alu_rob_addr,
    input  logic [ALU_NUM-1:0][31:0]           alu_data,
    input  logic [MEM_NUM-1:0]                 mem_valid,
    input  logic [MEM_NUM-1:0][AW-1:0]         mem_rob_addr,
    input  logic [MEM_NUM-1:0][31:0]           mem_data,
    input  logic                               br_valid,
    input  logic [AW-1:0]                      br_rob_addr,
    input  logic                               br_mispredict,
    input  logic [31:0]                        br_target,
    output logic [MACHINE_WIDTH-1:0]           retire_valid,
    output logic [MACHINE_WIDTH-1:0][4:0]      retire_creg,
    output logic [MACHINE_WIDTH-1:0][PW-1:0]   retire_preg,
    output logic [MACHINE_WIDTH-1:0][31:0]     retire_data,
`ifdef ROB_DEBUG_TRACE_EN
    output logic [MACHINE_WIDTH-1:0][31:0]     debug_wb_pc,
    output logic [MACHINE_WIDTH-1:0][3:0]      debug_wb_rf_wen,
    output logic [MACHINE_WIDTH-1:0][4:0]      debug_wb_rf_wnum,
    output logic [MACHINE_WIDTH-1:0][31:0]     debug_wb_rf_wdata,
`endif
    output logic                               branch_taken,
    output logic [31:0]                        pcbranch,
    output logic                               flush
);

    import rob_pkg::*;

    localparam logic [AW:0] READY_MAX = (AW+1)'(ROB_DEPTH - MACHINE_WIDTH);

    rob_entry_t  entries [ROB_DEPTH];
    logic [AW:0] head;
    logic [AW:0] tail;
    logic [AW:0] count;
    logic [AW:0] next_head;
    logic [AW:0] alloc_step;
    logic [AW-1:0] rd_addr [MACHINE_WIDTH];
    logic [1:0]  sel_valid;
    logic [1:0]  head_inc;
    logic        do_redirect;
    logic        alloc_fire;

    assign count       = tail - head;
    assign alloc_ready = (count <= READY_MAX);
    assign alloc_fire  = alloc_valid[0] & alloc_ready & ~do_redirect;
    assign next_head   = head + (AW+1)'(head_inc);
    assign alloc_step  = alloc_fire
                       ? (alloc_valid[1] ? (AW+1)'(2) : (AW+1)'(1))
                       : '0;

    // Slot indices at the head (retire) and at the tail (allocate).
    always_comb begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            rd_addr[i]      = head[AW-1:0] + AW'(i);
            rob_addr_new[i] = tail[AW-1:0] + AW'(i);
        end
    end

    rob_retire_sel u_sel (
        .head_valid    (entries[rd_addr[0]].valid),
        .head_done     (entries[rd_addr[0]].done),
        .head_redirect (entries[rd_addr[0]].redirect),
        .next_valid    (entries[rd_addr[1]].valid),
        .next_done     (entries[rd_addr[1]].done),
        .next_redirect (entries[rd_addr[1]].redirect),
        .retire_valid  (sel_valid),
        .head_inc      (head_inc),
        .redirect      (do_redirect)
    );

    // Head/tail pointers; a redirect empties the buffer behind the new head.
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else if (do_redirect) begin
            head <= next_head;
            tail <= next_head;
        end else begin
            head <= next_head;
            tail <= tail + alloc_step;
        end
    end

    // Entry state: retire clears, allocate fills, completion marks done.
    always_ff @(posedge clk) begin
        if (reset || do_redirect) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid    <= 1'b0;
                entries[i].done     <= 1'b0;
                entries[i].redirect <= 1'b0;
            end
        end else begin
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (sel_valid[i]) begin
                    entries[rd_addr[i]].valid    <= 1'b0;
                    entries[rd_addr[i]].done     <= 1'b0;
                    entries[rd_addr[i]].redirect <= 1'b0;
                end
            end
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (alloc_fire && alloc_valid[i]) begin
                    entries[rob_addr_new[i]].valid     <= 1'b1;
                    entries[rob_addr_new[i]].done      <= 1'b0;
                    entries[rob_addr_new[i]].creg      <= alloc_dst_creg[i];
                    entries[rob_addr_new[i]].preg      <= alloc_dst_preg[i];
                    entries[rob_addr_new[i]].is_branch <= alloc_is_branch[i];
                    entries[rob_addr_new[i]].redirect  <= 1'b0;
`ifdef ROB_DEBUG_TRACE_EN
                    entries[rob_addr_new[i]].pc        <= alloc_pc[i];
`endif
                end
            end
            for (int p = 0; p < ALU_NUM; p++) begin
                if (alu_valid[p] && entries[alu_rob_addr[p]].valid) begin
                    entries[alu_rob_addr[p]].done <= 1'b1;
                    entries[alu_rob_addr[p]].data <= alu_data[p];
                end
            end
            for (int p = 0; p < MEM_NUM; p++) begin
                if (mem_valid[p] && entries[mem_rob_addr[p]].valid) begin
                    entries[mem_rob_addr[p]].done <= 1'b1;
                    entries[mem_rob_addr[p]].data <= mem_data[p];
                end
            end
            if (br_valid && br_mispredict &&
                entries[br_rob_addr].valid &&
                entries[br_rob_addr].is_branch) begin
                entries[br_rob_addr].redirect <= 1'b1;
                entries[br_rob_addr].target   <= br_target;
            end
        end
    end

    // Retire ports read straight from the head entries.
    always_comb begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            retire_creg[i] = entries[rd_addr[i]].creg;
            retire_preg[i] = entries[rd_addr[i]].preg;
            retire_data[i] = entries[rd_addr[i]].data;
        end
    end

    assign retire_valid = sel_valid;
    assign branch_taken = do_redirect;
    assign flush        = do_redirect;
    assign pcbranch     = do_redirect ? entries[rd_addr[0]].target : 32'd0;

`ifdef ROB_DEBUG_TRACE_EN
    // Trace view of each retiring slot; zero when idle or in reset.
    always_comb begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            debug_wb_pc[i]       = 32'd0;
            debug_wb_rf_wen[i]   = 4'h0;
            debug_wb_rf_wnum[i]  = 5'd0;
            debug_wb_rf_wdata[i] = 32'd0;
            if (sel_valid[i] && !reset) begin
                debug_wb_pc[i]       = entries[rd_addr[i]].pc;
                debug_wb_rf_wen[i]   = (entries[rd_addr[i]].creg != 5'd0)
                                     ? 4'hF : 4'h0;
                debug_wb_rf_wnum[i]  = entries[rd_addr[i]].creg;
                debug_wb_rf_wdata[i] = entries[rd_addr[i]].data;
            end
        end
    end
`endif

endmodule
